tt_um_watbulb_fifo_exerciser: RTL
=================================

# tt_um_watbulb_fifo_exerciser

Micro-tile master for the team's 6-bit synchronous FIFO tile. It drives the FIFO's write/read side (`rd_en`, `wr_en`, `dat_in`) and consumes its outputs (`empty`, `full`, `dat_out`). It runs a fixed number of fill/drain rounds with an incrementing data pattern, checks capacity, ordering and flag behaviour, and reports a pass/fail summary on the same output pins.

## Interface
- `EXP_DEPTH`, default 3: number of writes the FIFO must accept before it asserts full.
- `MAX_OPS`, default 8: per-phase cap on strobes; reaching it without the terminating flag is a timeout.
- `ROUNDS`, default 4: number of fill+drain rounds before done.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low. Shared with the FIFO tile.
- `ui_in`  in  8: FIFO outputs. [7] = empty, [6] = full, [5:0] = FIFO read data.
- `uo_out`  out  8: [7] = rd_en, [6] = wr_en. [5:0] carries write data while wr_en=1; otherwise it carries status {done, pass, err_cnt[3:0]}.

## Operation
- All outputs are registered. While `rst_n` is low, `uo_out` = 0x00, state = FILL, `wr_val` = `rd_val` = 0, round = 0, `err_cnt` = 0.
- Pacing: every phase alternates a gap cycle (no strobe, `ui_in` sampled at the closing edge) and a strobe cycle (exactly one of rd_en/wr_en high for one cycle). Each state begins with a gap cycle. Strobes are never back-to-back.
- FILL, at the end of each gap:
  - If full=1: if writes != EXP_DEPTH, increment err. Go to DRAIN.
  - Else if writes == MAX_OPS: increment err (timeout). Go to DRAIN.
  - Else: strobe a write with `wdata` = `wr_val`, then `wr_val`++ (6-bit, wraps 63->0) and writes++.
- DRAIN, at the end of each gap:
  - If the previous cycle was a read strobe: compare `ui_in[5:0]` to `rd_val`, increment err on mismatch, then `rd_val`++ (wraps).
  - Then if empty=1: if reads != writes, increment err. Clear counts, round++. Go to DONE if round == ROUNDS, else FILL.
  - Else if reads == MAX_OPS: increment err. Go to the next round as above.
  - Else: strobe a read.
- Flag check: at any gap sample, full=1 and empty=1 together increments err (once per sample).
- `err_cnt` is 4 bits and saturates at 15. All increments in one sample are applied together, still saturating.
- DONE: no strobes. Status shows done=1 and pass = (`err_cnt`==0). DONE holds until reset.
- Reset mid-operation: everything returns to reset values on the next edge. `wr_val`/`rd_val` restart at 0.

## Timing
- Write: `wr_en`/`wdata` high for one cycle. The FIFO captures at that cycle's closing edge, and its registered full flag is current at the following gap sample.
- Read: `rd_en` high for one cycle. FIFO data updates at that edge and is captured at the end of the next gap (two-cycle read latency).
- Phase length with a healthy depth-D FIFO: 1 + 2·D cycles. A round is 2·(1 + 2·D) cycles.
- Status `[5:0]` updates in the cycle after the sample that changes it.
- The transition into DONE is registered: done=1 appears in the cycle after the final DRAIN gap.

## Test plan
- Healthy depth-3 FIFO model, defaults: the write data sequence is 0..11 and the read data matches. `uo_out` = 0x30 (done, pass) starting in cycle 57 after `rst_n` rises. No strobe occurs after that.
- Depth-4 FIFO model, EXP_DEPTH=3: one capacity error per round. `uo_out` final = 0x24.
- Healthy model, but bit 0 flipped on the 2nd read of round 1: `uo_out` final = 0x21.
- `ui_in` held at 0x00 (never full, never empty, data 0): fill timeout, 7 data mismatches and a drain timeout in round 1, then saturation. `uo_out` final = 0x2F.
- Reset pulsed low for one cycle during the round-2 drain: `uo_out` = 0x00 in the next cycle. The first write after release carries 0. The run ends at 0x30, 56 cycles after release.
- ROUNDS=22 with a healthy depth-3 model: the write data wraps 63->0,1 with no false mismatch. `uo_out` final = 0x30.

Source files
------------

// File: rtl/tt_um_watbulb_fifo_exerciser_if.sv
// Pin bundle between the FIFO exerciser and the FIFO tile it drives.
// ui_in carries the FIFO's {empty, full, dat_out}; uo_out carries {rd_en, wr_en, data/status}.
interface tt_um_watbulb_fifo_exerciser_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (input ui_in, output uo_out);
  modport slave (output ui_in, input uo_out);
endinterface

// File: rtl/tt_um_watbulb_fifo_exerciser.sv
// Fill/drain exerciser for the 6-bit FIFO tile: paced gap/strobe traffic with an
// incrementing pattern, capacity/order/flag checks and a saturating error count.
module tt_um_watbulb_fifo_exerciser #(
  parameter int EXP_DEPTH = 3,
  parameter int MAX_OPS   = 8,
  parameter int ROUNDS    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  tt_um_watbulb_fifo_exerciser_if.master        bus
);

  localparam int CNT_MAX = (MAX_OPS > EXP_DEPTH) ? MAX_OPS : EXP_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RND_W   = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXP_DEPTH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_OPS);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t           state_q;
  logic             strobe_q;
  logic             rd_pend_q;
  logic [5:0]       wr_val_q;
  logic [5:0]       rd_val_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [RND_W-1:0] round_q;
  logic [3:0]       err_q;
  logic [7:0]       uo_q;

  logic       fifo_empty, fifo_full;
  logic [5:0] fifo_rdata;
  logic       flag_err, data_err, fill_exit, fill_err, drain_exit, drain_err;
  logic [1:0] n_inc;
  logic [3:0] err_nxt;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [1:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {3'b000, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  // pass is only meaningful once the run is complete
  function automatic logic [5:0] status(input logic done, input logic [3:0] err);
    return {done, done & (err == 4'd0), err};
  endfunction

  assign fifo_empty = bus.ui_in[7];
  assign fifo_full  = bus.ui_in[6];
  assign fifo_rdata = bus.ui_in[5:0];
  assign bus.uo_out = uo_q;

  always_comb begin
    flag_err   = fifo_full & fifo_empty;
    data_err   = rd_pend_q & (fifo_rdata != rd_val_q);
    fill_exit  = fifo_full | (wr_cnt_q == MAX_C);
    fill_err   = fifo_full ? (wr_cnt_q != EXP_C) : (wr_cnt_q == MAX_C);
    drain_exit = fifo_empty | (rd_cnt_q == MAX_C);
    drain_err  = fifo_empty ? (rd_cnt_q != wr_cnt_q) : (rd_cnt_q == MAX_C);
    n_inc      = {1'b0, flag_err};
    if (state_q == FILL) n_inc = n_inc + {1'b0, fill_err};
    else                 n_inc = n_inc + {1'b0, data_err} + {1'b0, drain_err};
    err_nxt    = sat_add(err_q, n_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      strobe_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_val_q  <= '0;
      rd_val_q  <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      round_q   <= '0;
      err_q     <= '0;
      uo_q      <= '0;
    end else begin
      case (state_q)
        DONE: uo_q <= {2'b00, status(1'b1, err_q)};
        default: begin
          if (strobe_q) begin
            strobe_q <= 1'b0;
            uo_q     <= {2'b00, status(1'b0, err_q)};
          end else begin
            err_q <= err_nxt;
            if (state_q == FILL) begin
              if (fill_exit) begin
                state_q <= DRAIN;
                uo_q    <= {2'b00, status(1'b0, err_nxt)};
              end else begin
                strobe_q <= 1'b1;
                uo_q     <= {2'b01, wr_val_q};
                wr_val_q <= wr_val_q + 6'd1;
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
              end
            end else begin
              // the read strobe two cycles back has its data on the pins now
              rd_pend_q <= 1'b0;
              if (rd_pend_q) rd_val_q <= rd_val_q + 6'd1;
              if (drain_exit) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
                round_q  <= round_q + RND_W'(1);
                state_q  <= (round_q == LAST_RND) ? DONE : FILL;
                uo_q     <= {2'b00, status(round_q == LAST_RND, err_nxt)};
              end else begin
                strobe_q  <= 1'b1;
                rd_pend_q <= 1'b1;
                rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
                uo_q      <= {2'b10, status(1'b0, err_nxt)};
              end
            end
          end
        end
      endcase
    end
  end

endmodule
